// File: rtl/johnson_step_sched_if.sv
// rtl/johnson_step_sched_if.sv - control/status bundle between sequencer and its driver
interface johnson_step_sched_if #(
  parameter int PW = 22,
  parameter int CW = 8
);
  logic [PW-1:0] PERIOD;
  logic [CW-1:0] COUNT;
  logic          DIR_IN;
  logic          START;
  logic          STOP;
  logic          STEP;
  logic          CE;
  logic          DIR;
  logic          BUSY;
  logic          DONE;
  logic [CW-1:0] STEPS_LEFT;

  modport master (
    output PERIOD, COUNT, DIR_IN, START, STOP, STEP,
    input  CE, DIR, BUSY, DONE, STEPS_LEFT
  );

  modport slave (
    input  PERIOD, COUNT, DIR_IN, START, STOP, STEP,
    output CE, DIR, BUSY, DONE, STEPS_LEFT
  );
endinterface

// File: rtl/johnson_step_sched.sv
// rtl/johnson_step_sched.sv - CE/DIR scheduler for the Johnson ring (run, burst, single step)
module johnson_step_sched #(
  parameter int PW = 22,
  parameter int CW = 8
) (
  input logic                  CLK,
  input logic                  RESETN,
  johnson_step_sched_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;

  localparam logic [PW-1:0] ONE_P = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic [PW-1:0] per_l;
  logic          burst;
  logic          ce_r;
  logic          done_r;
  logic          busy_r;
  logic          dir_r;
  logic [CW-1:0] steps_r;

  logic [PW-1:0] presc_nxt;
  logic [CW-1:0] remaining;

  // Prescaler successor (wraps at the latched period) and the tick count left
  // once the CE currently on the output has been accounted for.
  always_comb begin
    presc_nxt = '0;
    remaining = steps_r;
    if (presc != per_l) begin
      presc_nxt = presc + ONE_P;
    end
    if (ce_r && burst) begin
      remaining = steps_r - ONE_C;
    end
  end

  // Sequencer: all outputs are registered; CE/DONE are scheduled one edge ahead.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state   <= S_IDLE;
      presc   <= '0;
      per_l   <= '0;
      burst   <= 1'b0;
      ce_r    <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      dir_r   <= 1'b0;
      steps_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ce_r   <= 1'b0;
          done_r <= 1'b0;
          if (bus.STOP) begin
            state <= S_IDLE;
          end else if (bus.START) begin
            // Prescaler is 0 in IDLE, so the first tick lands PERIOD+1 cycles
            // after acceptance; PERIOD=0 ticks straight away in cycle 1.
            state   <= S_RUN;
            busy_r  <= 1'b1;
            per_l   <= bus.PERIOD;
            burst   <= (bus.COUNT != '0);
            dir_r   <= bus.DIR_IN;
            steps_r <= bus.COUNT;
            presc   <= (bus.PERIOD == '0) ? '0 : ONE_P;
            ce_r    <= (bus.PERIOD == '0);
            done_r  <= (bus.PERIOD == '0) && (bus.COUNT == ONE_C);
          end else if (bus.STEP) begin
            state  <= S_STEP;
            busy_r <= 1'b1;
            dir_r  <= bus.DIR_IN;
            ce_r   <= 1'b1;
            done_r <= 1'b1;
          end
        end

        S_RUN: begin
          if (done_r) begin
            // Final burst tick was just issued.
            state   <= S_IDLE;
            busy_r  <= 1'b0;
            ce_r    <= 1'b0;
            done_r  <= 1'b0;
            presc   <= '0;
            steps_r <= remaining;
          end else if (bus.STOP) begin
            // Abort: remaining count is frozen as it stands.
            state  <= S_IDLE;
            busy_r <= 1'b0;
            ce_r   <= 1'b0;
            presc  <= '0;
          end else begin
            presc   <= presc_nxt;
            ce_r    <= (presc_nxt == '0);
            done_r  <= burst && (presc_nxt == '0) && (remaining == ONE_C);
            steps_r <= remaining;
          end
        end

        S_STEP: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
          ce_r   <= 1'b0;
          done_r <= 1'b0;
        end

        default: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
          ce_r   <= 1'b0;
          done_r <= 1'b0;
          presc  <= '0;
        end
      endcase
    end
  end

  assign bus.CE         = ce_r;
  assign bus.DONE       = done_r;
  assign bus.BUSY       = busy_r;
  assign bus.DIR        = dir_r;
  assign bus.STEPS_LEFT = steps_r;

endmodule

// File: tb/tb_johnson_step_sched.sv
// tb/tb_johnson_step_sched.sv - self-checking bench for johnson_step_sched
module tb_johnson_step_sched;

  logic CLK;
  logic RESETN;
  int   cyc;
  int   checks;
  int   errors;

  johnson_step_sched_if #(.PW(22), .CW(8)) bus ();

  johnson_step_sched #(.PW(22), .CW(8)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: a run is described by its acceptance cycle, period and
  // length; outputs follow from arithmetic on the cycle offset.
  int m_mode;   // 0 idle, 1 run, 2 single step
  int m_t0;
  int m_per;
  int m_cnt;
  int m_hold;
  bit m_dir;

  initial begin
    m_mode = 0; m_t0 = 0; m_per = 0; m_cnt = 0; m_hold = 0; m_dir = 0;
  end

  always @(negedge CLK) begin
    bit e_ce, e_busy, e_done;
    int e_steps, k, len;
    e_ce = 0; e_busy = 0; e_done = 0; e_steps = m_hold;
    if (!RESETN) begin
      m_mode = 0; m_hold = 0; m_dir = 0; e_steps = 0;
    end else if (m_mode == 1) begin
      k       = cyc - m_t0;
      len     = m_per + 1;
      e_busy  = 1;
      e_ce    = (k % len) == 0;
      e_done  = (m_cnt != 0) && (k == m_cnt * len);
      e_steps = (m_cnt == 0) ? 0 : m_cnt - (k - 1) / len;
    end else if (m_mode == 2) begin
      e_ce = 1; e_busy = 1; e_done = 1;
    end
    check("ce", bus.CE, e_ce);
    check("busy", bus.BUSY, e_busy);
    check("done", bus.DONE, e_done);
    check("dir", bus.DIR, m_dir);
    check("steps_left", bus.STEPS_LEFT, e_steps);
    if (RESETN) begin
      case (m_mode)
        0: begin
          if (bus.STOP) begin
            m_mode = 0;
          end else if (bus.START) begin
            m_mode = 1; m_t0 = cyc; m_per = bus.PERIOD; m_cnt = bus.COUNT; m_dir = bus.DIR_IN;
          end else if (bus.STEP) begin
            m_mode = 2; m_dir = bus.DIR_IN;
          end
        end
        1: begin
          if (e_done) begin
            m_mode = 0; m_hold = 0;
          end else if (bus.STOP) begin
            m_mode = 0; m_hold = e_steps;
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  // Per-test recording of which relative cycles showed CE / DONE / BUSY.
  int ce_q[$];
  int done_q[$];
  int busy_n;

  task automatic clear_rec();
    ce_q.delete(); done_q.delete(); busy_n = 0;
  endtask

  task automatic sample(input int rel);
    @(negedge CLK);
    if (bus.CE)   ce_q.push_back(rel);
    if (bus.DONE) done_q.push_back(rel);
    if (bus.BUSY) busy_n++;
  endtask

  task automatic idle_inputs();
    bus.START = 0; bus.STOP = 0; bus.STEP = 0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RESETN = 0; idle_inputs();
    @(posedge CLK); @(posedge CLK); #1;
    RESETN = 1;
  endtask

  initial begin
    checks = 0; errors = 0;
    RESETN = 0;
    bus.PERIOD = '0; bus.COUNT = '0; bus.DIR_IN = 0;
    idle_inputs();
    do_reset();
    check("reset_ce", bus.CE, 0);
    check("reset_busy", bus.BUSY, 0);
    check("reset_steps", bus.STEPS_LEFT, 0);

    // Burst: PERIOD=3, COUNT=4, DIR_IN=1.
    clear_rec();
    @(posedge CLK); #1;
    bus.PERIOD = 3; bus.COUNT = 4; bus.DIR_IN = 1; bus.START = 1;
    for (int rel = 1; rel <= 20; rel++) begin
      @(posedge CLK); #1;
      if (rel == 1) bus.START = 0;
      sample(rel);
      if (rel == 4)  check("t1_steps_at_ce1", bus.STEPS_LEFT, 4);
      if (rel == 5)  check("t1_steps_after_ce1", bus.STEPS_LEFT, 3);
      if (rel == 17) check("t1_steps_end", bus.STEPS_LEFT, 0);
    end
    check("t1_ce_count", ce_q.size(), 4);
    for (int i = 0; i < ce_q.size() && i < 4; i++) check("t1_ce_cycle", ce_q[i], 4 * (i + 1));
    check("t1_done_count", done_q.size(), 1);
    if (done_q.size() > 0) check("t1_done_cycle", done_q[0], 16);
    check("t1_busy_cycles", busy_n, 16);
    check("t1_dir", bus.DIR, 1);

    // Continuous at PERIOD=0, STOP in cycle 6.
    clear_rec();
    @(posedge CLK); #1;
    bus.PERIOD = 0; bus.COUNT = 0; bus.DIR_IN = 0; bus.START = 1;
    for (int rel = 1; rel <= 12; rel++) begin
      @(posedge CLK); #1;
      bus.START = 0;
      bus.STOP = (rel == 6);
      sample(rel);
    end
    check("t2_ce_count", ce_q.size(), 6);
    if (ce_q.size() > 0) check("t2_last_ce", ce_q[ce_q.size() - 1], 6);
    check("t2_busy_cycles", busy_n, 6);
    check("t2_done_count", done_q.size(), 0);

    // Single step from IDLE.
    clear_rec();
    @(posedge CLK); #1;
    bus.DIR_IN = 0; bus.STEP = 1;
    for (int rel = 1; rel <= 4; rel++) begin
      @(posedge CLK); #1;
      bus.STEP = 0;
      sample(rel);
    end
    check("t3_ce_count", ce_q.size(), 1);
    if (ce_q.size() > 0) check("t3_ce_cycle", ce_q[0], 1);
    check("t3_done_count", done_q.size(), 1);
    check("t3_busy_cycles", busy_n, 1);

    // START+STEP together enters RUN; mid-run changes are ignored.
    clear_rec();
    @(posedge CLK); #1;
    bus.PERIOD = 5; bus.COUNT = 0; bus.DIR_IN = 0; bus.START = 1; bus.STEP = 1;
    for (int rel = 1; rel <= 30; rel++) begin
      @(posedge CLK); #1;
      bus.START = (rel == 3); bus.STEP = (rel == 3);
      if (rel == 3) begin bus.PERIOD = 1; bus.COUNT = 3; bus.DIR_IN = 1; end
      sample(rel);
    end
    check("t4_ce_count", ce_q.size(), 5);
    for (int i = 0; i < ce_q.size() && i < 5; i++) check("t4_ce_cycle", ce_q[i], 6 * (i + 1));
    check("t4_done_count", done_q.size(), 0);
    check("t4_dir", bus.DIR, 0);
    @(posedge CLK); #1; bus.STOP = 1;
    @(posedge CLK); #1; bus.STOP = 0;

    // START and STOP together in IDLE.
    clear_rec();
    @(posedge CLK); #1;
    bus.PERIOD = 0; bus.COUNT = 2; bus.START = 1; bus.STOP = 1;
    for (int rel = 1; rel <= 5; rel++) begin
      @(posedge CLK); #1;
      idle_inputs();
      sample(rel);
    end
    check("t5_ce_count", ce_q.size(), 0);
    check("t5_busy_cycles", busy_n, 0);

    // Async reset mid-burst after the third CE.
    clear_rec();
    @(posedge CLK); #1;
    bus.PERIOD = 2; bus.COUNT = 10; bus.DIR_IN = 1; bus.START = 1;
    for (int rel = 1; rel <= 9; rel++) begin
      @(posedge CLK); #1;
      bus.START = 0;
      sample(rel);
    end
    check("t6_ce_before_reset", ce_q.size(), 3);
    @(posedge CLK); #2;
    RESETN = 0;
    #1;
    check("t6_async_ce", bus.CE, 0);
    check("t6_async_busy", bus.BUSY, 0);
    check("t6_async_done", bus.DONE, 0);
    check("t6_async_dir", bus.DIR, 0);
    check("t6_async_steps", bus.STEPS_LEFT, 0);
    @(posedge CLK); #1;
    RESETN = 1;
    clear_rec();
    for (int rel = 1; rel <= 10; rel++) begin
      @(posedge CLK); #1;
      sample(rel);
    end
    check("t6_ce_after_release", ce_q.size(), 0);
    check("t6_done_after_release", done_q.size(), 0);

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK); #1;
      if (RESETN == 0) begin
        RESETN = 1;
      end else if ($urandom_range(0, 299) == 0) begin
        RESETN = 0;
      end
      bus.PERIOD = $urandom_range(0, 4);
      bus.COUNT  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      bus.DIR_IN = $urandom_range(0, 1);
      bus.START  = ($urandom_range(0, 9) == 0);
      bus.STOP   = ($urandom_range(0, 39) == 0);
      bus.STEP   = ($urandom_range(0, 11) == 0);
    end
    @(posedge CLK); #1;
    RESETN = 1; idle_inputs();
    @(posedge CLK); @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
